// File: rtl/uart_tx_fifo_drain.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_drain
//
// UART transmit engine acting as the reader side of a 256x8 TX FIFO whose
// read data is registered (RD_LAT clocks from the read-strobe cycle to valid
// data). When the FIFO is non-empty the engine issues a single-clock read
// strobe, waits out the read latency, captures the byte together with the
// frame configuration, and serialises it as:
//     start(0), 7 or 8 data bits LSB first, optional parity, stop(1).
// Every serial bit spans OVERSAMPLE pulses of the shared 16x baud enable,
// counted from the first clock of the start bit.
//
// Ports
//   clk_i         system clock (also the FIFO read clock)
//   rst_ni        asynchronous active-low reset
//   baud_en_i     single-cycle 16x baud tick (may be held high continuously)
//   bit8_i        1 = 8 data bits, 0 = 7 data bits
//   parity_en_i   1 = append a parity bit
//   odd_n_even_i  1 = odd parity, 0 = even parity
//   fifo_empty_i  FIFO empty flag
//   fifo_data_i   FIFO registered read data
//   fifo_rdb_o    active-low FIFO read strobe (one clock per byte)
//   tx_o          serial output, idle high, registered
//   tx_busy_o     high from the pop cycle until the stop bit completes
// -----------------------------------------------------------------------------
module uart_tx_fifo_drain #(
    parameter int OVERSAMPLE = 16,  // baud ticks per serial bit
    parameter int RD_LAT     = 2    // FIFO read latency, must be >= 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       baud_en_i,
    input  logic       bit8_i,
    input  logic       parity_en_i,
    input  logic       odd_n_even_i,
    input  logic       fifo_empty_i,
    input  logic [7:0] fifo_data_i,
    output logic       fifo_rdb_o,
    output logic       tx_o,
    output logic       tx_busy_o
);

    // -------------------------------------------------------------------------
    // Local parameters
    // -------------------------------------------------------------------------
    localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

    // WAIT holds for RD_LAT-1 clocks; the counter starts at 0 on entry.
    localparam int WAIT_W = 4;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POP    = 3'd1,
        S_WAIT   = 3'd2,
        S_LOAD   = 3'd3,
        S_START  = 3'd4,
        S_DATA   = 3'd5,
        S_PARITY = 3'd6,
        S_STOP   = 3'd7
    } state_e;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_e              state_q,  state_d;
    logic [TICK_W-1:0]   tick_q,   tick_d;     // baud ticks within current bit
    logic [2:0]          bit_q,    bit_d;      // data bit index
    logic [WAIT_W-1:0]   wait_q,   wait_d;     // read-latency counter
    logic [7:0]          shift_q,  shift_d;    // outgoing data, LSB on the line
    logic                bit8_q,   bit8_d;     // frame config latched at LOAD
    logic                par_en_q, par_en_d;
    logic                par_q,    par_d;      // precomputed parity bit
    logic                tx_q,     tx_d;
    logic                rdb_q,    rdb_d;
    logic                busy_q,   busy_d;

    // -------------------------------------------------------------------------
    // Parity of the incoming byte. Bit 7 only takes part in 8-bit frames, so
    // it is masked by bit8_i before the XOR reduction.
    // -------------------------------------------------------------------------
    logic [7:0] par_bits;

    for (genvar gi = 0; gi < 8; gi++) begin : g_par_mask
        if (gi == 7) begin : g_msb
            assign par_bits[gi] = fifo_data_i[gi] & bit8_i;
        end else begin : g_lsb
            assign par_bits[gi] = fifo_data_i[gi];
        end
    end

    // -------------------------------------------------------------------------
    // Bit timing helpers
    // -------------------------------------------------------------------------
    logic       serial_state;
    logic       bit_end;
    logic [2:0] last_bit;

    // The tick counter only advances while a frame is on the line; baud ticks
    // seen during IDLE/POP/WAIT/LOAD are deliberately dropped.
    assign serial_state = (state_q == S_START) || (state_q == S_DATA) ||
                          (state_q == S_PARITY) || (state_q == S_STOP);

    // A bit ends on the baud tick that would take the counter past its last
    // value, i.e. on the OVERSAMPLE-th tick of the bit.
    assign bit_end  = serial_state && baud_en_i && (tick_q == TICK_LAST);
    assign last_bit = bit8_q ? 3'd7 : 3'd6;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        wait_d   = wait_q;
        shift_d  = shift_q;
        bit8_d   = bit8_q;
        par_en_d = par_en_q;
        par_d    = par_q;

        if (serial_state && baud_en_i) begin
            if (tick_q == TICK_LAST) begin
                tick_d = '0;
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                // FIFO_EMPTY is only looked at here, so toggling it while a
                // frame is in flight has no effect.
                if (!fifo_empty_i) begin
                    state_d = S_POP;
                end
            end

            S_POP: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = S_LOAD;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            S_LOAD: begin
                // Read data is valid now; capture it along with the frame
                // configuration so later config changes cannot corrupt the
                // frame in progress.
                shift_d  = fifo_data_i;
                bit8_d   = bit8_i;
                par_en_d = parity_en_i;
                par_d    = (^par_bits) ^ odd_n_even_i;
                tick_d   = '0;
                bit_d    = '0;
                state_d  = S_START;
            end

            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == last_bit) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode. Outputs are derived from the next state and registered,
    // so they line up with the state they belong to and never glitch.
    // -------------------------------------------------------------------------
    always_comb begin
        tx_d   = 1'b1;
        rdb_d  = 1'b1;
        busy_d = 1'b1;

        case (state_d)
            S_IDLE:   busy_d = 1'b0;
            S_POP:    rdb_d  = 1'b0;
            S_START:  tx_d   = 1'b0;
            S_DATA:   tx_d   = shift_d[0];
            S_PARITY: tx_d   = par_d;
            default:  tx_d   = 1'b1;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers. Reset drives TX high immediately; a byte in flight is lost.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            wait_q   <= '0;
            shift_q  <= '0;
            bit8_q   <= 1'b0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            rdb_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            wait_q   <= wait_d;
            shift_q  <= shift_d;
            bit8_q   <= bit8_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            rdb_q    <= rdb_d;
            busy_q   <= busy_d;
        end
    end

    assign tx_o       = tx_q;
    assign fifo_rdb_o = rdb_q;
    assign tx_busy_o  = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// -----------------------------------------------------------------------------
// Testbench for uart_tx_fifo_drain.
// A queue-based FIFO model with a two-clock registered read feeds the DUT.
// Every run records TX / TX_BUSY / FIFO_RDB and the driven baud enable per
// clock, then compares the trace with a frame-level reference that derives
// each expected waveform from the byte, its configuration and the baud ticks.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo_drain;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud_en;
    logic       bit8;
    logic       parity_en;
    logic       odd_n_even;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rdb;
    logic       tx;
    logic       tx_busy;

    always #5 clk = ~clk;

    uart_tx_fifo_drain dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .baud_en_i    (baud_en),
        .bit8_i       (bit8),
        .parity_en_i  (parity_en),
        .odd_n_even_i (odd_n_even),
        .fifo_empty_i (fifo_empty),
        .fifo_data_i  (fifo_data),
        .fifo_rdb_o   (fifo_rdb),
        .tx_o         (tx),
        .tx_busy_o    (tx_busy)
    );

    typedef struct {
        logic [7:0] data;
        bit         b8;
        bit         pen;
        bit         odd;
    } frame_t;

    typedef struct {
        logic [7:0]  data;
        bit          b8;
        bit          pen;
        bit          odd;
        int          exp_bits;   // serial bits in the frame
        logic [11:0] exp_wave;   // expected line level per bit, bit 0 first
    } vec_t;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc   = 0;
    int           baud_mode;      // 0 = random 1-in-3, N = every Nth clock
    logic [7:0]   fifo_q[$];
    frame_t       fr_q[$];
    logic [7:0]   stage1 = 8'h00;
    logic         rdb_prev = 1'b1;

    logic tr_tx[$], tr_busy[$], tr_rdb[$], tr_baud[$];
    logic e_tx[$],  e_busy[$],  e_rdb[$];

    // -------------------------------------------------------------------------
    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: sample the outputs of the new cycle, then drive its inputs.
    task automatic clock_cycle();
        @(posedge clk);
        #1;
        tr_tx.push_back(tx);
        tr_busy.push_back(tx_busy);
        tr_rdb.push_back(fifo_rdb);
        // FIFO model: strobe seen at an edge -> stage1 -> read data one clock later
        fifo_data = stage1;
        if (!rdb_prev && fifo_q.size() > 0) stage1 = fifo_q.pop_front();
        rdb_prev   = fifo_rdb;
        fifo_empty = (fifo_q.size() == 0);
        if (baud_mode == 0) baud_en = ($urandom_range(0, 2) == 0);
        else                baud_en = ((cyc % baud_mode) == 0);
        tr_baud.push_back(baud_en);
        cyc++;
    endtask

    task automatic push_frame(input logic [7:0] d);
        frame_t f;
        f.data = d; f.b8 = bit8; f.pen = parity_en; f.odd = odd_n_even;
        fifo_q.push_back(d);
        fr_q.push_back(f);
    endtask

    // Serial bit sequence of one frame, bit 0 = start bit.
    function automatic logic [11:0] frame_bits(input frame_t f, output int nb);
        logic [11:0] b;
        logic        par;
        int          nd;
        b   = '0;
        nd  = f.b8 ? 8 : 7;
        par = f.odd;
        nb  = 0;
        b[nb] = 1'b0; nb++;
        for (int i = 0; i < nd; i++) begin
            b[nb] = f.data[i];
            par   = par ^ f.data[i];
            nb++;
        end
        if (f.pen) begin b[nb] = par; nb++; end
        b[nb] = 1'b1; nb++;
        return b;
    endfunction

    // Reference: pop at p, line idle for pop/wait/load, then each bit holds
    // until OS baud ticks have been seen; next pop one IDLE clock later.
    task automatic build_expect(input int p0);
        int n, p, k, t, ticks, nb;
        logic [11:0] bits;
        n = tr_tx.size();
        e_tx.delete(); e_busy.delete(); e_rdb.delete();
        for (int i = 0; i < n; i++) begin
            e_tx.push_back(1'b1); e_busy.push_back(1'b0); e_rdb.push_back(1'b1);
        end
        p = p0;
        k = 0;
        while (p >= 0 && p < n && k < fr_q.size()) begin
            bits = frame_bits(fr_q[k], nb);
            e_rdb[p] = 1'b0;
            for (int j = 0; j < 3; j++) if (p + j < n) e_busy[p + j] = 1'b1;
            t = p + 3;
            ticks = 0;
            while (t < n && ticks < OS * nb) begin
                e_tx[t]   = bits[ticks / OS];
                e_busy[t] = 1'b1;
                if (tr_baud[t] === 1'b1) ticks++;
                t++;
            end
            k++;
            p = t + 1;
        end
    endtask

    task automatic compare_trace(input string name);
        int    nbad, first;
        logic  a, e, af, ef;
        string sn;
        for (int s = 0; s < 3; s++) begin
            nbad = 0; first = -1; af = 1'b0; ef = 1'b0;
            sn = (s == 0) ? "tx" : ((s == 1) ? "tx_busy" : "fifo_rdb");
            for (int i = 0; i < tr_tx.size(); i++) begin
                a = (s == 0) ? tr_tx[i] : ((s == 1) ? tr_busy[i] : tr_rdb[i]);
                e = (s == 0) ? e_tx[i]  : ((s == 1) ? e_busy[i]  : e_rdb[i]);
                if (a !== e) begin
                    if (first < 0) begin first = i; af = a; ef = e; end
                    nbad++;
                end
            end
            n_cmp++;
            if (nbad != 0) begin
                n_bad++;
                $display("FAIL %s %s: %0d bad cycles, first at cycle %0d got %b expected %b",
                         name, sn, nbad, first, af, ef);
            end else begin
                $display("ok   %s %s: %0d cycles match reference", name, sn, tr_tx.size());
            end
        end
    endtask

    // Run queued frames (if any) to completion and compare with the reference.
    task automatic run(input string name, input int min_cycles, input int toggle_at);
        int p0, extra;
        tr_tx.delete(); tr_busy.delete(); tr_rdb.delete(); tr_baud.delete();
        p0 = (fifo_q.size() > 0) ? 1 : -1;
        for (int i = 0; i < min_cycles; i++) begin
            if (i == toggle_at) begin
                bit8 = ~bit8; parity_en = ~parity_en; odd_n_even = ~odd_n_even;
            end
            clock_cycle();
        end
        extra = 0;
        while ((tx_busy !== 1'b0 || fifo_q.size() > 0) && extra < 20000) begin
            clock_cycle();
            extra++;
        end
        check({name, " idle at end"}, int'(tx_busy), 0);
        for (int i = 0; i < 3; i++) clock_cycle();
        build_expect(p0);
        compare_trace(name);
        fr_q.delete();
    endtask

    function automatic int count_low_rdb();
        int c = 0;
        for (int i = 0; i < tr_rdb.size(); i++) if (tr_rdb[i] === 1'b0) c++;
        return c;
    endfunction

    // -------------------------------------------------------------------------
    vec_t tbl[6];

    initial begin
        int   busy_cnt, e_idx, s_idx, nf;
        logic [11:0] got;

        tbl[0] = '{8'h55, 1'b1, 1'b0, 1'b0, 10, 12'h2AA};
        tbl[1] = '{8'hA3, 1'b1, 1'b1, 1'b0, 11, 12'h546};
        tbl[2] = '{8'hA3, 1'b1, 1'b1, 1'b1, 11, 12'h746};
        tbl[3] = '{8'hA3, 1'b0, 1'b1, 1'b0, 10, 12'h346};
        tbl[4] = '{8'h00, 1'b0, 1'b0, 1'b0,  9, 12'h100};
        tbl[5] = '{8'hFF, 1'b0, 1'b1, 1'b1, 10, 12'h2FE};

        rst_n = 1'b0; baud_en = 1'b0; bit8 = 1'b1; parity_en = 1'b0;
        odd_n_even = 1'b0; fifo_empty = 1'b1; fifo_data = 8'h00; baud_mode = 1;

        repeat (3) @(posedge clk);
        #1;
        check("reset tx", int'(tx), 1);
        check("reset fifo_rdb", int'(fifo_rdb), 1);
        check("reset tx_busy", int'(tx_busy), 0);
        rst_n = 1'b1;

        // ---- table-driven single frames, baud enable held high ----
        for (int v = 0; v < 6; v++) begin
            bit8 = tbl[v].b8; parity_en = tbl[v].pen; odd_n_even = tbl[v].odd;
            baud_mode = 1;
            push_frame(tbl[v].data);
            run($sformatf("vec%0d", v), 10, -1);
            busy_cnt = 0;
            foreach (tr_busy[i]) if (tr_busy[i] === 1'b1) busy_cnt++;
            check($sformatf("vec%0d busy clocks", v), busy_cnt, 3 + OS * tbl[v].exp_bits);
            check($sformatf("vec%0d rdb pulses", v), count_low_rdb(), 1);
            got = '0;
            for (int k = 0; k < tbl[v].exp_bits; k++) got[k] = tr_tx[4 + OS * k + OS / 2];
            check($sformatf("vec%0d line bits", v), int'(got), int'(tbl[v].exp_wave));
        end

        // ---- two back-to-back frames, baud enable every 4th clock ----
        bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0; baud_mode = 4;
        push_frame(8'h01);
        push_frame(8'h80);
        run("two_frames", 100, -1);
        check("two_frames rdb pulses", count_low_rdb(), 2);
        e_idx = -1; s_idx = -1;
        for (int i = 1; i < tr_busy.size(); i++)
            if (e_idx < 0 && tr_busy[i - 1] === 1'b1 && tr_busy[i] === 1'b0) e_idx = i;
        for (int i = (e_idx < 0 ? 0 : e_idx); i < tr_tx.size(); i++)
            if (s_idx < 0 && tr_tx[i] === 1'b0) s_idx = i;
        check("two_frames idle-to-start gap", s_idx - e_idx, 4);
        s_idx = -1;
        for (int i = 0; i < tr_tx.size(); i++) if (s_idx < 0 && tr_tx[i] === 1'b0) s_idx = i;
        check("two_frames frame1 length 637..640",
              int'((e_idx - s_idx) >= 637 && (e_idx - s_idx) <= 640), 1);

        // ---- FIFO empty for 1000 clocks ----
        baud_mode = 1;
        run("empty", 1000, -1);
        check("empty rdb pulses", count_low_rdb(), 0);

        // ---- config toggled mid-frame must not alter the frame ----
        bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
        push_frame(8'h5A);
        run("toggle", 10, 40);
        bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;

        // ---- reset during data bit 3 of 0x00 ----
        push_frame(8'h00);
        fr_q.delete();
        for (int i = 0; i < 75; i++) clock_cycle();
        check("rst busy in data bit3", int'(tx_busy), 1);
        check("rst tx in data bit3", int'(tx), 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst async tx", int'(tx), 1);
        check("rst async busy", int'(tx_busy), 0);
        check("rst async rdb", int'(fifo_rdb), 1);
        clock_cycle();
        clock_cycle();
        rst_n = 1'b1;
        run("after_reset", 40, -1);
        push_frame(8'hC3);
        run("resume", 10, -1);

        // ---- randomized frames against the reference ----
        for (int r = 0; r < 4; r++) begin
            bit8       = $urandom_range(0, 1);
            parity_en  = $urandom_range(0, 1);
            odd_n_even = $urandom_range(0, 1);
            baud_mode  = $urandom_range(0, 3);
            nf = $urandom_range(1, 3);
            for (int f = 0; f < nf; f++) push_frame(8'($urandom_range(0, 255)));
            run($sformatf("rand%0d", r), 10, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
